// File: rtl/cv32e40x_pkg.sv
// ---- cv32e40x_pkg : shared register-file types and sizes | rev 1.0 ----
`default_nettype none

package cv32e40x_pkg;

  typedef logic [4:0] rf_addr_t;

  localparam int REGFILE_NUM_READ_PORTS  = 3;
  localparam int REGFILE_NUM_WRITE_PORTS = 2;

  // Lane 1 occupies the upper word so a 64-bit pair result maps onto {odd, even}
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } rf_wdata_pair_t;

endpackage

`default_nettype wire

// File: rtl/cv32e40x_rf_wr_decode.sv
// ---- cv32e40x_rf_wr_decode : lane enables/addresses -> per-word write enable and lane select | rev 1.0 ----
`default_nettype none

module cv32e40x_rf_wr_decode
  import cv32e40x_pkg::*;
#(
  parameter int NUM_WORDS = 32
) (
  input  logic     [REGFILE_NUM_WRITE_PORTS-1:0] we_i,
  input  rf_addr_t [REGFILE_NUM_WRITE_PORTS-1:0] waddr_i,
  output logic     [NUM_WORDS-1:0]               wen_o,
  output logic     [NUM_WORDS-1:0]               lane_sel_o
);

  // Word 0 is never enabled and words beyond NUM_WORDS have no decode slot,
  // so x0 and out-of-range writes fall away; lane 1 is evaluated last to win.
  always_comb begin
    wen_o      = '0;
    lane_sel_o = '0;
    for (int w = 1; w < NUM_WORDS; w++) begin
      if (we_i[0] && (waddr_i[0] == rf_addr_t'(w))) begin
        wen_o[w] = 1'b1;
      end
      if (we_i[1] && (waddr_i[1] == rf_addr_t'(w))) begin
        wen_o[w]      = 1'b1;
        lane_sel_o[w] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cv32e40x_rf_pair.sv
// ---- cv32e40x_rf_pair : two-lane-write integer register file with optional write-through bypass | rev 1.0 ----
`default_nettype none

module cv32e40x_rf_pair
  import cv32e40x_pkg::*;
#(
  parameter int NUM_WORDS      = 32,
  parameter int NUM_READ_PORTS = REGFILE_NUM_READ_PORTS,
  parameter bit BYPASS         = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  rf_addr_t [NUM_READ_PORTS-1:0]          raddr_i,
  output logic     [NUM_READ_PORTS-1:0][31:0]    rdata_o,
  input  logic     [REGFILE_NUM_WRITE_PORTS-1:0] we_i,
  input  rf_addr_t [REGFILE_NUM_WRITE_PORTS-1:0] waddr_i,
  input  logic     [63:0]                        wdata_i,
  output logic                                   wr_collision_o
);

  rf_wdata_pair_t              wpair;
  logic [NUM_WORDS-1:0]        wen;
  logic [NUM_WORDS-1:0]        lane_sel;
  logic [NUM_WORDS-1:0][31:0]  mem_q;

  assign wpair = wdata_i;

  cv32e40x_rf_wr_decode #(
    .NUM_WORDS (NUM_WORDS)
  ) u_wr_decode (
    .we_i       (we_i),
    .waddr_i    (waddr_i),
    .wen_o      (wen),
    .lane_sel_o (lane_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (wen[w]) begin
          mem_q[w] <= lane_sel[w] ? wpair.hi : wpair.lo;
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      for (int w = 1; w < NUM_WORDS; w++) begin
        if (raddr_i[p] == rf_addr_t'(w)) begin
          rdata_o[p] = mem_q[w];
        end
      end
      // Forwarding only applies to addresses the array could actually hold
      if (BYPASS && (raddr_i[p] != '0) && (int'(raddr_i[p]) < NUM_WORDS)) begin
        if (we_i[0] && (waddr_i[0] == raddr_i[p])) begin
          rdata_o[p] = wpair.lo;
        end
        if (we_i[1] && (waddr_i[1] == raddr_i[p])) begin
          rdata_o[p] = wpair.hi;
        end
      end
    end
  end

  assign wr_collision_o = (&we_i) && (waddr_i[0] == waddr_i[1]) && (waddr_i[0] != '0);

  if (NUM_WORDS < 32) begin : g_range_chk
    a_wr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
      !(we_i[0] && (int'(waddr_i[0]) >= NUM_WORDS)) && !(we_i[1] && (int'(waddr_i[1]) >= NUM_WORDS)))
      else $warning("rf_pair: write beyond NUM_WORDS discarded");
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_x0_chk
    a_x0_zero: assert property (@(posedge clk) (raddr_i[p] == '0) |-> (rdata_o[p] == '0));
  end

  a_col_we: assert property (@(posedge clk) wr_collision_o |-> (&we_i));

endmodule

`default_nettype wire
